muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 160 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a single sign-fix cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             hilo_read,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] work_q, work_d;     // product, or {remainder, quotient}
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    work_d   = work_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    // op_type[0]=0 selects the signed variants
    a_neg = ~op_type[0] & src_a[WIDTH-1];
    b_neg = ~op_type[0] & src_b[WIDTH-1];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;

    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];

    prod_fix = neg_q  ? -work_q : work_q;
    quo_fix  = neg_q  ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          opnd_d   = op_type[1] ? b_mag : a_mag;
          work_d   = {{WIDTH{1'b0}}, (op_type[1] ? a_mag : b_mag)};
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          dz_d     = op_type[1] && (src_b == '0);
          is_div_d = op_type[1];
          cnt_d    = '0;
          state_d  = op_type[1] ? S_DIV : S_MUL;
        end else if (!op_valid) begin
          if (mthi) hi_d = mt_data;
          if (mtlo) lo_d = mt_data;
        end
      end
      S_MUL: begin
        work_d = {mul_sum, work_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        work_d = {div_rem, work_q[WIDTH-2:0], div_ge};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // a zero divisor yields an all-ones quotient and |a| as remainder, so only LO needs forcing
            hi_d = rem_fix;
            lo_d = dz_q ? '1 : quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  // NOTE: all state, including the operand/work registers, is cleared by reset so nothing X escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      work_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      work_q   <= work_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (op_valid | hilo_read | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model compared every cycle,
// directed literal cases, then randomized traffic including flush and mt writes.
module tb_muldiv_seq;

  localparam int W   = 32;
  localparam int LAT = W + 1;  // edges after the accepting edge until HI/LO update

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [1:0]   op_type = 2'b00;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         mthi = 1'b0, mtlo = 1'b0;
  logic [W-1:0] mt_data = '0;
  logic         hilo_read = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_type(op_type),
    .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .hilo_read(hilo_read), .flush(flush), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: returns {hi, lo}
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    logic [63:0] r;
    sa = a;
    sb = b;
    case (op)
      2'b00: r = longint'(sa) * longint'(sb);
      2'b01: r = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Behavioural model: a countdown to completion plus the pending result
  int          m_left;
  logic [W-1:0] m_hi, m_lo;
  logic        m_done;
  logic [63:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_pend = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            {m_hi, m_lo} = m_pend;
            m_done = 1'b1;
          end
        end
      end else if (op_valid && !flush) begin
        m_pend = ref_op(op_type, src_a, src_b);
        m_left = LAT;
      end else if (!op_valid) begin
        if (mthi) m_hi = mt_data;
        if (mtlo) m_lo = mt_data;
      end
    end
  end

  // Compare process: outputs checked against the model every cycle, away from the edge
  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = (m_left > 0);
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("busy", 64'(busy), 64'(exp_busy));
    check("done", 64'(done), 64'(m_done));
    check("stall", 64'(stall), 64'(exp_busy & (op_valid | hilo_read | mthi | mtlo)));
  end

  task automatic idle_inputs();
    op_valid = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_read = 1'b0; flush = 1'b0;
  endtask

  // Issue one op from IDLE and wait (bounded) for done; check latency and literal result
  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo);
    int n;
    op_valid = 1'b1; op_type = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    n = 0;
    while (n < LAT + 8 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(LAT));
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    #1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // mthi in IDLE
    mthi = 1'b1; mt_data = 32'h1234;
    @(posedge clk); #1;
    idle_inputs();
    check("mthi_hi", 64'(hi), 64'h1234);

    do_op("mult",   2'b00, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("divu",   2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
    do_op("div_n",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_ov", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    do_op("divu_z", 2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    do_op("multu",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    // back-to-back: accepted in the done cycle right after FIX
    do_op("b2b",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1);

    // hilo_read while busy stalls through FIX; HI/LO hold until the result lands
    op_valid = 1'b1; op_type = 2'b01; src_a = 32'd1000; src_b = 32'd1000;
    @(posedge clk); #1;
    op_valid = 1'b0;
    n = 0;
    while (n < LAT + 8 && !done) begin
      if (n == 3) hilo_read = 1'b1;
      if (n == LAT - 1) check("stall_in_fix", 64'(stall), 64'h1);
      if (n == 5) check("hold_lo", 64'(lo), 64'h1);
      @(posedge clk); #1;
      n++;
    end
    check("stall_after_done", 64'(stall), 64'h0);
    check("stall_lo", 64'(lo), 64'd1_000_000);
    idle_inputs();
    @(posedge clk); #1;

    // flush at iteration 10
    op_valid = 1'b1; op_type = 2'b00; src_a = 32'd7; src_b = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_lo", 64'(lo), 64'd1_000_000);
    repeat (LAT + 2) @(posedge clk);
    #1;
    do_op("post_flush", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

    // asynchronous reset mid-DIV
    op_valid = 1'b1; op_type = 2'b10; src_a = 32'd12345; src_b = 32'd67;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'h0);
    check("arst_lo", 64'(lo), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("arst_no_result", 64'(lo), 64'h0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      op_valid  = ($urandom_range(0, 2) == 0);
      op_type   = 2'($urandom_range(0, 3));
      src_a     = rand_operand();
      src_b     = rand_operand();
      mthi      = ($urandom_range(0, 3) == 0);
      mtlo      = ($urandom_range(0, 3) == 0);
      mt_data   = $urandom;
      hilo_read = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (LAT + 4) @(posedge clk);
    #1;
    check("final_idle", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
